// File: rtl/pcpu_branch_predictor_if.sv
// Fetch/decode-side bundle for the branch predictor: IF lookup, ID update and perf counters.
// The core drives through the master modport; the predictor sits on the slave modport.
interface pcpu_branch_predictor_if #(
  parameter int XLEN   = 32,
  parameter int PERF_W = 32
);
  logic              pred_en;
  logic [XLEN-1:0]   lk_pc;
  logic              pred_hit;
  logic              pred_taken;
  logic [XLEN-1:0]   pred_target;
  logic              upd_valid;
  logic [XLEN-1:0]   upd_pc;
  logic              upd_uncond;
  logic              upd_taken;
  logic [XLEN-1:0]   upd_target;
  logic              upd_mispred;
  logic [PERF_W-1:0] perf_lookups;
  logic [PERF_W-1:0] perf_mispred;

  modport master (
    output pred_en, lk_pc, upd_valid, upd_pc, upd_uncond, upd_taken, upd_target, upd_mispred,
    input  pred_hit, pred_taken, pred_target, perf_lookups, perf_mispred
  );

  modport slave (
    input  pred_en, lk_pc, upd_valid, upd_pc, upd_uncond, upd_taken, upd_target, upd_mispred,
    output pred_hit, pred_taken, pred_target, perf_lookups, perf_mispred
  );
endinterface

// File: rtl/pcpu_branch_predictor.sv
// Direct-mapped BTB with per-entry saturating counters and perf counters for the 5-stage RV32 core.
// Lookup is combinational from the registered table; updates land on the next rising edge.
module pcpu_branch_predictor #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16,
  parameter int CTR_W   = 2,
  parameter int PERF_W  = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  pcpu_branch_predictor_if.slave bp
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;

  localparam logic [CTR_W-1:0] CTR_MAX = {CTR_W{1'b1}};
  localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(1 << (CTR_W - 1));
  localparam logic [CTR_W-1:0] CTR_WNT = CTR_W'((1 << (CTR_W - 1)) - 1);

  logic             valid_q  [ENTRIES];
  logic             valid_d  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [TAG_W-1:0] tag_d    [ENTRIES];
  logic [XLEN-1:0]  target_q [ENTRIES];
  logic [XLEN-1:0]  target_d [ENTRIES];
  logic [CTR_W-1:0] ctr_q    [ENTRIES];
  logic [CTR_W-1:0] ctr_d    [ENTRIES];

  logic [PERF_W-1:0] lookups_q, lookups_d;
  logic [PERF_W-1:0] mispred_q, mispred_d;

  logic [IDX_W-1:0] lk_idx_s, upd_idx_s;
  logic [TAG_W-1:0] lk_tag_s, upd_tag_s;
  logic             lk_hit_s, upd_hit_s;
  logic             unused_pc_bits_s;

  function automatic logic [CTR_W-1:0] sat_inc(input logic [CTR_W-1:0] c);
    if (c == CTR_MAX) return c;
    else              return c + CTR_W'(1);
  endfunction

  function automatic logic [CTR_W-1:0] sat_dec(input logic [CTR_W-1:0] c);
    if (c == {CTR_W{1'b0}}) return c;
    else                    return c - CTR_W'(1);
  endfunction

  assign lk_idx_s         = bp.lk_pc[IDX_W+1:2];
  assign lk_tag_s         = bp.lk_pc[XLEN-1:IDX_W+2];
  assign upd_idx_s        = bp.upd_pc[IDX_W+1:2];
  assign upd_tag_s        = bp.upd_pc[XLEN-1:IDX_W+2];
  assign unused_pc_bits_s = ^bp.upd_pc[1:0];

  // Lookup path: reads only the registered table, so a same-cycle update is not bypassed.
  always_comb begin
    lk_hit_s       = valid_q[lk_idx_s] && (tag_q[lk_idx_s] == lk_tag_s);
    bp.pred_hit    = lk_hit_s;
    bp.pred_taken  = bp.pred_en && lk_hit_s && ctr_q[lk_idx_s][CTR_W-1];
    if (bp.pred_taken) begin
      bp.pred_target = target_q[lk_idx_s];
    end else begin
      bp.pred_target = bp.lk_pc + XLEN'(4);
    end
  end

  // Table next-state: reset clears valids and parks counters at weakly-not-taken.
  always_comb begin
    valid_d   = valid_q;
    tag_d     = tag_q;
    target_d  = target_q;
    ctr_d     = ctr_q;
    upd_hit_s = valid_q[upd_idx_s] && (tag_q[upd_idx_s] == upd_tag_s);
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_d[i] = 1'b0;
        ctr_d[i]   = CTR_WNT;
      end
    end else if (bp.upd_valid) begin
      if (upd_hit_s) begin
        if (bp.upd_uncond) begin
          ctr_d[upd_idx_s]    = CTR_MAX;
          target_d[upd_idx_s] = bp.upd_target;
        end else if (bp.upd_taken) begin
          ctr_d[upd_idx_s]    = sat_inc(ctr_q[upd_idx_s]);
          target_d[upd_idx_s] = bp.upd_target;
        end else begin
          ctr_d[upd_idx_s]    = sat_dec(ctr_q[upd_idx_s]);
        end
      end else if (bp.upd_uncond || bp.upd_taken) begin
        // Miss on a taken transfer allocates, silently evicting any aliasing entry.
        valid_d[upd_idx_s]  = 1'b1;
        tag_d[upd_idx_s]    = upd_tag_s;
        target_d[upd_idx_s] = bp.upd_target;
        ctr_d[upd_idx_s]    = bp.upd_uncond ? CTR_MAX : CTR_WT;
      end else begin
        valid_d[upd_idx_s]  = valid_q[upd_idx_s];
      end
    end else begin
      valid_d = valid_q;
    end
  end

  // Perf counter next-state; both wrap naturally at 2^PERF_W.
  always_comb begin
    if (reset) begin
      lookups_d = {PERF_W{1'b0}};
      mispred_d = {PERF_W{1'b0}};
    end else begin
      lookups_d = lookups_q + PERF_W'(bp.upd_valid);
      mispred_d = mispred_q + PERF_W'(bp.upd_valid & bp.upd_mispred);
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    valid_q   <= valid_d;
    tag_q     <= tag_d;
    target_q  <= target_d;
    ctr_q     <= ctr_d;
    lookups_q <= lookups_d;
    mispred_q <= mispred_d;
  end

  assign bp.perf_lookups = lookups_q;
  assign bp.perf_mispred = mispred_q;
endmodule
